// File: rtl/flex_stp_pkg.sv
// Shared types and helpers for the flex_stp deframer.
// Optional even parity per lane is enabled by FLEX_STP_PARITY_EN.
package flex_stp_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  localparam int IDLE_W = 256;

  function automatic logic [IDLE_W-1:0] lane_idle(input int n);
    lane_idle = '0;
    for (int i = 0; i < IDLE_W; i++)
      if (i < n) lane_idle[i] = 1'b1;
  endfunction

endpackage

// File: rtl/flex_stp_deframer_if.sv
// Word handshake bundle between the deframer and its consumer.
// Carries parity_err only when FLEX_STP_PARITY_EN is defined.
interface flex_stp_deframer_if #(
  parameter int NUM_BITS  = 8,
  parameter int NUM_LANES = 1
);
  logic [NUM_LANES*NUM_BITS-1:0] word_out;
  logic                          word_valid;
  logic                          word_ready;
`ifdef FLEX_STP_PARITY_EN
  logic [NUM_LANES-1:0]          parity_err;
`endif

  modport master (
    output word_out,
    output word_valid,
`ifdef FLEX_STP_PARITY_EN
    output parity_err,
`endif
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
`ifdef FLEX_STP_PARITY_EN
    input  parity_err,
`endif
    output word_ready
  );
endinterface

// File: rtl/flex_stp_lane.sv
// One serial lane: shift register with selectable direction.
// Adds a parity accumulator when FLEX_STP_PARITY_EN is defined.
module flex_stp_lane
  import flex_stp_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift,
  input  logic                din,
`ifdef FLEX_STP_PARITY_EN
  input  logic                par_bit,
  output logic                perr,
`endif
  output logic [NUM_BITS-1:0] word
);

  localparam logic [NUM_BITS-1:0] IDLE =
    NUM_BITS'(lane_idle(NUM_BITS));

  logic [NUM_BITS-1:0] sr;
  logic [NUM_BITS-1:0] sr_nxt;

  assign sr_nxt = (SHIFT_MSB != 0)
    ? {sr[NUM_BITS-2:0], din}
    : {din, sr[NUM_BITS-1:1]};

`ifdef FLEX_STP_PARITY_EN
  logic acc;

  // the parity shift leaves the data bits in place
  assign word = sr;
  assign perr = acc ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= IDLE;
      acc <= 1'b0;
    end else if (shift) begin
      if (par_bit) begin
        acc <= 1'b0;
      end else begin
        sr  <= sr_nxt;
        acc <= acc ^ din;
      end
    end
  end
`else
  assign word = sr_nxt;

  always_ff @(posedge clk) begin
    if (rst || clr) sr <= IDLE;
    else if (shift) sr <= sr_nxt;
  end
`endif

endmodule

// File: rtl/flex_stp_deframer.sv
// Multi-lane serial-to-parallel deframer with a valid/ready holding register.
// Define FLEX_STP_PARITY_EN for one trailing even-parity bit per lane.
module flex_stp_deframer
  import flex_stp_pkg::*;
#(
  parameter  int NUM_BITS  = 8,
  parameter  int NUM_LANES = 1,
  parameter  int SHIFT_MSB = 1,
  localparam int CW        = $clog2(NUM_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_enable,
  input  logic [NUM_LANES-1:0] serial_in,
  input  logic                 frame_clr,
  flex_stp_deframer_if.master  bus,
  output logic [CW-1:0]        bit_count,
  output logic                 overrun,
  input  logic                 overrun_clr
);

`ifdef FLEX_STP_PARITY_EN
  localparam int LAST = NUM_BITS;
`else
  localparam int LAST = NUM_BITS - 1;
`endif

  localparam logic [NUM_BITS-1:0] IDLE =
    NUM_BITS'(lane_idle(NUM_BITS));

  logic                          last;
  logic                          done;
  logic                          load;
  logic                          drop;
  logic [NUM_LANES*NUM_BITS-1:0] asm_word;
  hold_state_t                   state;
`ifdef FLEX_STP_PARITY_EN
  logic [NUM_LANES-1:0]          asm_perr;
`endif

  assign last = bit_count == CW'(LAST);
  assign done = shift_enable && !frame_clr && last;
  assign load = done &&
    (state == HOLD_EMPTY || bus.word_ready);
  assign drop = done && state == HOLD_FULL &&
    !bus.word_ready;

  assign bus.word_valid = state == HOLD_FULL;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    flex_stp_lane #(
      .NUM_BITS  (NUM_BITS),
      .SHIFT_MSB (SHIFT_MSB)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (frame_clr),
      .shift   (shift_enable),
      .din     (serial_in[k]),
`ifdef FLEX_STP_PARITY_EN
      .par_bit (last),
      .perr    (asm_perr[k]),
`endif
      .word    (asm_word[k*NUM_BITS +: NUM_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || frame_clr) bit_count <= '0;
    else if (shift_enable)
      bit_count <= last ? '0 : bit_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD_EMPTY;
      bus.word_out <= {NUM_LANES{IDLE}};
`ifdef FLEX_STP_PARITY_EN
      bus.parity_err <= '0;
`endif
    end else begin
      if (load) begin
        bus.word_out <= asm_word;
`ifdef FLEX_STP_PARITY_EN
        bus.parity_err <= asm_perr;
`endif
      end
      unique case (1'b1)
        load:                  state <= HOLD_FULL;
        !load && bus.word_ready: state <= HOLD_EMPTY;
        default: ;
      endcase
    end
  end

  // a drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_flex_stp_deframer.sv
// Bench for flex_stp_deframer: 4-lane MSB-first and 1-lane LSB-first units.
// Parity checks are compiled in when FLEX_STP_PARITY_EN is defined.
module tb_flex_stp_deframer;

  localparam int NB = 8;
  localparam int NL = 4;
  localparam int CW = $clog2(NB + 1);
`ifdef FLEX_STP_PARITY_EN
  localparam int WL = NB + 1;
`else
  localparam int WL = NB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          shift_enable = 1'b0;
  logic [NL-1:0] serial_in = '0;
  logic          frame_clr = 1'b0;
  logic          word_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          ovr_a, ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flex_stp_deframer_if #(.NUM_BITS(NB), .NUM_LANES(NL)) bus_a ();
  flex_stp_deframer_if #(.NUM_BITS(NB), .NUM_LANES(1))  bus_b ();

  assign bus_a.word_ready = word_ready;
  assign bus_b.word_ready = word_ready;

  flex_stp_deframer #(
    .NUM_BITS(NB), .NUM_LANES(NL), .SHIFT_MSB(1)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .frame_clr    (frame_clr),
    .bus          (bus_a),
    .bit_count    (cnt_a),
    .overrun      (ovr_a),
    .overrun_clr  (overrun_clr)
  );

  flex_stp_deframer #(
    .NUM_BITS(NB), .NUM_LANES(1), .SHIFT_MSB(0)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in[0:0]),
    .frame_clr    (frame_clr),
    .bus          (bus_b),
    .bit_count    (cnt_b),
    .overrun      (ovr_b),
    .overrun_clr  (overrun_clr)
  );

  // reference: bits of the current word per lane, plus a one-slot buffer
  bit               m_bits [NL][WL];
  int               m_cnt;
  bit               m_valid, m_ovr;
  logic [NL*NB-1:0] m_wa;
  logic [NB-1:0]    m_wb;
  logic [NL-1:0]    m_pa;
  logic             m_pb;

  task automatic model_step();
    bit drop;
    bit p;
    if (rst) begin
      m_cnt = 0; m_valid = 0; m_ovr = 0;
      m_wa = '1; m_wb = '1; m_pa = '0; m_pb = 1'b0;
      return;
    end
    drop = 0;
    if (m_valid && word_ready) m_valid = 0;
    if (frame_clr) begin
      m_cnt = 0;
    end else if (shift_enable) begin
      for (int k = 0; k < NL; k++) m_bits[k][m_cnt] = serial_in[k];
      m_cnt++;
      if (m_cnt == WL) begin
        m_cnt = 0;
        if (m_valid) begin
          drop = 1;
        end else begin
          m_valid = 1;
          for (int k = 0; k < NL; k++) begin
            p = 0;
            for (int i = 0; i < WL; i++) p ^= m_bits[k][i];
            m_pa[k] = p;
            for (int i = 0; i < NB; i++)
              m_wa[k*NB + NB-1-i] = m_bits[k][i];
          end
          for (int i = 0; i < NB; i++) m_wb[i] = m_bits[0][i];
          m_pb = m_pa[0];
        end
      end
    end
    if (drop) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    check("model_valid_a", 64'(bus_a.word_valid), 64'(m_valid));
    check("model_valid_b", 64'(bus_b.word_valid), 64'(m_valid));
    check("model_word_a", 64'(bus_a.word_out), 64'(m_wa));
    check("model_word_b", 64'(bus_b.word_out), 64'(m_wb));
    check("model_count_a", 64'(cnt_a), 64'(m_cnt));
    check("model_count_b", 64'(cnt_b), 64'(m_cnt));
    check("model_ovr_a", 64'(ovr_a), 64'(m_ovr));
    check("model_ovr_b", 64'(ovr_b), 64'(m_ovr));
`ifdef FLEX_STP_PARITY_EN
    check("model_perr_a", 64'(bus_a.parity_err), 64'(m_pa));
    check("model_perr_b", 64'(bus_b.parity_err), 64'(m_pb));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // lane k sends data[k*8+:8] first bit = MSB, then its parity bit
  task automatic send_word(input logic [31:0] data,
                           input logic [3:0]  pflip,
                           input bit rdy_mid, input bit rdy_last,
                           input int gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gaps; g++) begin
        shift_enable = 0;
        word_ready = rdy_mid;
        tick();
      end
      shift_enable = 1;
      word_ready = (i == WL-1) ? rdy_last : rdy_mid;
      for (int k = 0; k < NL; k++) begin
        if (i < NB) serial_in[k] = data[k*NB + NB-1-i];
        else serial_in[k] = ^data[k*NB +: NB] ^ pflip[k];
      end
      tick();
    end
    shift_enable = 0;
  endtask

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h80, 8'h80, 8'h01};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[3] = '{8'h01, 8'h01, 8'h80};
    vecs[4] = '{8'hF0, 8'hF0, 8'h0F};

    tick();
    tick();
    rst = 0;
    check("rst_word_a", 64'(bus_a.word_out), 64'(32'hFFFF_FFFF));
    check("rst_valid", 64'(bus_a.word_valid), 64'd0);
    check("rst_count", 64'(cnt_a), 64'd0);
    check("rst_ovr", 64'(ovr_a), 64'd0);

    foreach (vecs[v]) begin
      send_word({24'h0, vecs[v].bits}, 4'h0, 1, 1, 0, WL);
      check("vec_valid", 64'(bus_a.word_valid), 64'd1);
      check("vec_word_a", 64'(bus_a.word_out[7:0]), 64'(vecs[v].exp_a));
      check("vec_word_b", 64'(bus_b.word_out), 64'(vecs[v].exp_b));
      word_ready = 1;
      tick();
      check("vec_valid_1cyc", 64'(bus_a.word_valid), 64'd0);
    end

    // backpressure and overrun
    send_word(32'h3C, 4'h0, 0, 0, 0, WL);
    check("bp_ovr0", 64'(ovr_a), 64'd0);
    send_word(32'hC3, 4'h0, 0, 0, 0, WL);
    check("bp_word", 64'(bus_a.word_out), 64'h3C);
    check("bp_valid", 64'(bus_a.word_valid), 64'd1);
    check("bp_ovr1", 64'(ovr_a), 64'd1);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    check("ovr_clr", 64'(ovr_a), 64'd0);
    overrun_clr = 1;
    send_word(32'h77, 4'h0, 0, 0, 0, WL);
    overrun_clr = 0;
    check("ovr_set_wins", 64'(ovr_a), 64'd1);
    check("ovr_word_kept", 64'(bus_a.word_out), 64'h3C);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;

    // consume and reload on the same edge
    send_word(32'h96, 4'h0, 0, 1, 0, WL);
    check("sim_word", 64'(bus_a.word_out), 64'h96);
    check("sim_valid", 64'(bus_a.word_valid), 64'd1);
    check("sim_ovr", 64'(ovr_a), 64'd0);

    // reset mid-word
    send_word(32'hFF, 4'h0, 1, 1, 0, 5);
    rst = 1;
    tick();
    rst = 0;
    check("mrst_word", 64'(bus_a.word_out), 64'(32'hFFFF_FFFF));
    check("mrst_valid", 64'(bus_a.word_valid), 64'd0);
    check("mrst_count", 64'(cnt_a), 64'd0);
    send_word(32'h81, 4'h0, 1, 1, 0, WL);
    check("mrst_next", 64'(bus_a.word_out), 64'h81);

    // frame_clr mid-word with a pending word
    word_ready = 1;
    tick();
    send_word(32'h3C, 4'h0, 0, 0, 0, WL);
    send_word(32'hFF, 4'h0, 0, 0, 0, 5);
    frame_clr = 1;
    shift_enable = 1;
    tick();
    frame_clr = 0;
    shift_enable = 0;
    check("fclr_count", 64'(cnt_a), 64'd0);
    check("fclr_valid", 64'(bus_a.word_valid), 64'd1);
    check("fclr_word", 64'(bus_a.word_out), 64'h3C);
    send_word(32'h42, 4'h0, 1, 1, 0, WL);
    check("fclr_next", 64'(bus_a.word_out), 64'h42);

    send_word(32'hC5, 4'h0, 1, 1, 2, WL);
    check("gap_word", 64'(bus_a.word_out), 64'hC5);

`ifdef FLEX_STP_PARITY_EN
    word_ready = 1;
    tick();
    send_word(32'h0403_0201, 4'b0100, 1, 1, 0, WL);
    check("par_word", 64'(bus_a.word_out), 64'h0403_0201);
    check("par_err", 64'(bus_a.parity_err), 64'b0100);
`endif

    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(199) == 0);
      frame_clr = ($urandom_range(29) == 0);
      shift_enable = ($urandom_range(3) != 0);
      word_ready = ($urandom_range(1) == 1);
      overrun_clr = ($urandom_range(9) == 0);
      serial_in = NL'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
